// File: rtl/uart_pkg.sv
// Shared register map, bit indices and FSM encodings for uart_fifo_slave.
package uart_pkg;

    localparam logic [31:0] ADDR_CTRL   = 32'd0;
    localparam logic [31:0] ADDR_BAUD   = 32'd1;
    localparam logic [31:0] ADDR_TXDATA = 32'd2;
    localparam logic [31:0] ADDR_RXDATA = 32'd3;
    localparam logic [31:0] ADDR_STATUS = 32'd4;

    localparam int unsigned CTRL_TX_EN    = 0;
    localparam int unsigned CTRL_RX_EN    = 1;
    localparam int unsigned CTRL_STOP2    = 2;
    localparam int unsigned CTRL_IRQ_RXNE = 3;
    localparam int unsigned CTRL_IRQ_TXE  = 4;
    localparam int unsigned CTRL_PAR_EN   = 5;
    localparam int unsigned CTRL_PAR_ODD  = 6;

    localparam int unsigned ST_TX_FULL   = 0;
    localparam int unsigned ST_TX_EMPTY  = 1;
    localparam int unsigned ST_RX_FULL   = 2;
    localparam int unsigned ST_RX_EMPTY  = 3;
    localparam int unsigned ST_TX_BUSY   = 4;
    localparam int unsigned ST_OVERRUN   = 5;
    localparam int unsigned ST_FRAME_ERR = 6;
    localparam int unsigned ST_PAR_ERR   = 7;

    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a pop on a full FIFO frees room for a same-cycle push.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/uart_fifo_slave.sv
// Memory-mapped UART slave with TX/RX FIFOs, sticky status and level interrupt.
// Parity generation/checking is built only when UART_PARITY_EN is defined.
module uart_fifo_slave
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned DIV_RST    = 13021
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_WEnable,
    input  logic [31:0] i_WAddr,
    input  logic [31:0] i_WData,
    input  logic        i_REnable,
    input  logic [31:0] i_RAddr,
    output logic [31:0] o_RData,
    output logic        o_Err,
    input  logic        i_Rx,
    output logic        o_Tx,
    output logic        o_Irq
);
`ifdef UART_PARITY_EN
    localparam logic [6:0] CtrlMask = 7'h7f;
`else
    localparam logic [6:0] CtrlMask = 7'h1f;
`endif
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BW = $clog2(DATA_W);
    localparam logic [BW-1:0]    BitLast = BW'(DATA_W - 1);
    localparam logic [DIV_W-1:0] BaudMin = DIV_W'(2);

    logic [6:0]       ctrl_q;
    logic [DIV_W-1:0] baud_q;
    logic             overrun_q, ferr_q, perr_q, err_q;
    logic [31:0]      rdata_q, rdata_d, status;
    logic             par_en, par_odd, tx_busy, bus_err;

    logic              tx_push, tx_pop, tx_full, tx_empty;
    logic [DATA_W-1:0] tx_dout;
    logic [CW-1:0]     tx_count;
    logic              rx_pop, rx_full, rx_empty;
    logic [DATA_W-1:0] rx_dout;
    logic [CW-1:0]     rx_count;

    tx_state_e         tx_state_q;
    logic [DIV_W-1:0]  tx_div_q, tx_cnt_q;
    logic [DATA_W-1:0] tx_shift_q;
    logic [BW-1:0]     tx_bit_q;
    logic              tx_par_q, tx_stop2_q, tx_q;

    rx_state_e         rx_state_q;
    logic [DIV_W-1:0]  rx_div_q, rx_cnt_q;
    logic [DATA_W-1:0] rx_shift_q;
    logic [BW-1:0]     rx_bit_q;
    logic              rx_s1_q, rx_s2_q, rx_prev_q, rx_pbad_q;
    logic              rx_push_q, rx_ferr_q, rx_perr_q;

    assign par_en  = ctrl_q[CTRL_PAR_EN];
    assign par_odd = ctrl_q[CTRL_PAR_ODD];
    assign tx_busy = (tx_state_q != TxIdle);
    assign tx_push = i_WEnable && (i_WAddr == ADDR_TXDATA);
    assign tx_pop  = !tx_busy && ctrl_q[CTRL_TX_EN] && !tx_empty;
    assign rx_pop  = i_REnable && (i_RAddr == ADDR_RXDATA);
    assign bus_err = (i_WEnable && (i_WAddr > ADDR_STATUS || i_WAddr == ADDR_RXDATA
                                    || (tx_push && tx_full && !tx_pop)))
                   || (i_REnable && (i_RAddr > ADDR_STATUS || i_RAddr == ADDR_TXDATA));

    assign o_RData = rdata_q;
    assign o_Err   = err_q;
    assign o_Tx    = tx_q;
    assign o_Irq   = (ctrl_q[CTRL_IRQ_RXNE] & ~rx_empty)
                   | (ctrl_q[CTRL_IRQ_TXE] & tx_empty & ~tx_busy)
                   | overrun_q | ferr_q | perr_q;

    uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i(i_Clk), .rst_i(i_Rst), .push_i(tx_push), .pop_i(tx_pop),
        .din_i(i_WData[DATA_W-1:0]), .dout_o(tx_dout), .full_o(tx_full),
        .empty_o(tx_empty), .count_o(tx_count)
    );

    uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i(i_Clk), .rst_i(i_Rst), .push_i(rx_push_q), .pop_i(rx_pop),
        .din_i(rx_shift_q), .dout_o(rx_dout), .full_o(rx_full),
        .empty_o(rx_empty), .count_o(rx_count)
    );

    always_comb begin
        status               = '0;
        status[ST_TX_FULL]   = tx_full;
        status[ST_TX_EMPTY]  = tx_empty;
        status[ST_RX_FULL]   = rx_full;
        status[ST_RX_EMPTY]  = rx_empty;
        status[ST_TX_BUSY]   = tx_busy;
        status[ST_OVERRUN]   = overrun_q;
        status[ST_FRAME_ERR] = ferr_q;
        status[ST_PAR_ERR]   = perr_q;
        status[15:8]         = 8'(rx_count);
    end

    always_comb begin
        rdata_d = '0;
        case (i_RAddr)
            ADDR_CTRL:   rdata_d = 32'(ctrl_q);
            ADDR_BAUD:   rdata_d = 32'(baud_q);
            ADDR_RXDATA: rdata_d = rx_empty ? '0 : 32'(rx_dout);
            ADDR_STATUS: rdata_d = status;
            default:     rdata_d = '0;
        endcase
    end

    // Sticky flags: a hardware set in the same cycle as a write-1-to-clear wins.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            ctrl_q    <= '0;
            baud_q    <= DIV_W'(DIV_RST);
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= bus_err;
            if (i_REnable) rdata_q <= rdata_d;
            if (i_WEnable && i_WAddr == ADDR_CTRL) ctrl_q <= i_WData[6:0] & CtrlMask;
            if (i_WEnable && i_WAddr == ADDR_BAUD) begin
                baud_q <= (i_WData[DIV_W-1:0] < BaudMin) ? BaudMin : i_WData[DIV_W-1:0];
            end
            if (i_WEnable && i_WAddr == ADDR_STATUS) begin
                overrun_q <= overrun_q & ~i_WData[ST_OVERRUN];
                ferr_q    <= ferr_q & ~i_WData[ST_FRAME_ERR];
                perr_q    <= perr_q & ~i_WData[ST_PAR_ERR];
            end
            if (rx_push_q && rx_full && !rx_pop) overrun_q <= 1'b1;
            if (rx_ferr_q) ferr_q <= 1'b1;
            if (rx_perr_q) perr_q <= 1'b1;
        end
    end

    // Divisor and stop-bit count are latched at frame start so mid-frame writes wait a frame.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            tx_state_q <= TxIdle;
            tx_q       <= 1'b1;
            tx_div_q   <= '0;
            tx_cnt_q   <= '0;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            tx_par_q   <= 1'b0;
            tx_stop2_q <= 1'b0;
        end else if (tx_state_q == TxIdle) begin
            if (tx_pop) begin
                tx_state_q <= TxStart;
                tx_q       <= 1'b0;
                tx_shift_q <= tx_dout;
                tx_div_q   <= baud_q;
                tx_cnt_q   <= baud_q - 1'b1;
                tx_bit_q   <= '0;
                tx_par_q   <= (^tx_dout) ^ par_odd;
                tx_stop2_q <= ctrl_q[CTRL_STOP2];
            end
        end else if (tx_cnt_q != '0) begin
            tx_cnt_q <= tx_cnt_q - 1'b1;
        end else begin
            tx_cnt_q <= tx_div_q - 1'b1;
            case (tx_state_q)
                TxStart: begin
                    tx_state_q <= TxData;
                    tx_q       <= tx_shift_q[0];
                    tx_shift_q <= tx_shift_q >> 1;
                end
                TxData: begin
                    if (tx_bit_q != BitLast) begin
                        tx_bit_q   <= tx_bit_q + 1'b1;
                        tx_q       <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                    end else if (par_en) begin
                        tx_state_q <= TxParity;
                        tx_q       <= tx_par_q;
                    end else begin
                        tx_state_q <= TxStop;
                        tx_q       <= 1'b1;
                    end
                end
                TxParity: begin
                    tx_state_q <= TxStop;
                    tx_q       <= 1'b1;
                end
                TxStop: begin
                    if (tx_stop2_q) tx_stop2_q <= 1'b0;
                    else tx_state_q <= TxIdle;
                end
                default: tx_state_q <= TxIdle;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RxIdle;
            rx_div_q   <= '0;
            rx_cnt_q   <= '0;
            rx_shift_q <= '0;
            rx_bit_q   <= '0;
            rx_pbad_q  <= 1'b0;
            rx_push_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_perr_q  <= 1'b0;
        end else begin
            rx_s1_q   <= i_Rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            rx_push_q <= 1'b0;
            rx_ferr_q <= 1'b0;
            rx_perr_q <= 1'b0;
            if (rx_state_q == RxIdle) begin
                if (ctrl_q[CTRL_RX_EN] && rx_prev_q && !rx_s2_q) begin
                    rx_state_q <= RxStart;
                    rx_div_q   <= baud_q;
                    rx_cnt_q   <= (baud_q >> 1) - 1'b1;
                    rx_bit_q   <= '0;
                    rx_pbad_q  <= 1'b0;
                end
            end else if (rx_cnt_q != '0) begin
                rx_cnt_q <= rx_cnt_q - 1'b1;
            end else begin
                rx_cnt_q <= rx_div_q - 1'b1;
                case (rx_state_q)
                    RxStart: rx_state_q <= rx_s2_q ? RxIdle : RxData;
                    RxData: begin
                        rx_shift_q <= {rx_s2_q, rx_shift_q[DATA_W-1:1]};
                        if (rx_bit_q != BitLast) rx_bit_q <= rx_bit_q + 1'b1;
                        else rx_state_q <= par_en ? RxParity : RxStop;
                    end
                    RxParity: begin
                        rx_pbad_q  <= rx_s2_q != ((^rx_shift_q) ^ par_odd);
                        rx_state_q <= RxStop;
                    end
                    RxStop: begin
                        rx_state_q <= RxIdle;
                        if (!rx_s2_q) begin
                            rx_ferr_q <= 1'b1;
                        end else begin
                            rx_push_q <= 1'b1;
                            rx_perr_q <= rx_pbad_q;
                        end
                    end
                    default: rx_state_q <= RxIdle;
                endcase
            end
        end
    end
endmodule
